// File: rtl/key_cmd_decoder.sv
// -----------------------------------------------------------------------------
// key_cmd_decoder
//
// Sits between the USB keycode PIO output and the two ball movers. Debounces
// the raw 8-bit HID keycode and turns it into per-player left/right/jump
// commands. Commands change only on the frame boundary (falling edge of vs), so
// the movers see a single stable command set for each frame. Jump is
// edge-triggered: each key press produces exactly one frame-long pulse.
//
// Ports
//   Clk         in   1  system clock (50 MHz), single clock domain
//   Reset       in   1  asynchronous, active-low reset
//   keycode     in   8  raw HID keycode from the PIO, 8'h00 = no key
//   vs          in   1  VGA vertical sync, active low; falling edge = frame boundary
//   key_stable  out  8  debounced keycode (for the hex display)
//   frame_tick  out  1  one-Clk pulse per frame boundary
//   left        out  2  left[i]  : player i moving left
//   right       out  2  right[i] : player i moving right
//   jump        out  2  jump[i]  : high for exactly one frame per press
//
// Jump FSM (one per player)
//   state | meaning
//   IDLE  | jump key not seen; waiting for a debounced press
//   PEND  | press seen; pulse will start at the next frame edge
//   FIRE  | jump output high for the current frame
//   HOLD  | pulse done; waiting for the key to be released
// -----------------------------------------------------------------------------
module key_cmd_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [7:0]  P0_LEFT         = 8'h04,
  parameter logic [7:0]  P0_RIGHT        = 8'h07,
  parameter logic [7:0]  P0_JUMP         = 8'h1A,
  parameter logic [7:0]  P1_LEFT         = 8'h50,
  parameter logic [7:0]  P1_RIGHT        = 8'h4F,
  parameter logic [7:0]  P1_JUMP         = 8'h52
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       vs,
  output logic [7:0] key_stable,
  output logic       frame_tick,
  output logic [1:0] left,
  output logic [1:0] right,
  output logic [1:0] jump
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [7:0]       kc_q;
  logic             vs_q;
  logic             vs_d;
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             fe;

  logic [1:0]       st0, st1;
  logic [1:0]       st0_nxt, st1_nxt;
  logic             jump0_nxt, jump1_nxt;
  logic             hit0, hit1;

  // ---------------------------------------------------------------------------
  // Input registers. Both vs history stages come out of reset high so that
  // leaving reset with vs idle (high) never looks like a frame edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      kc_q <= 8'h00;
      vs_q <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      kc_q <= keycode;
      vs_q <= vs;
      vs_d <= vs_q;
    end
  end

  assign fe = vs_d & ~vs_q;

  // ---------------------------------------------------------------------------
  // Debounce: a new candidate restarts the count; the candidate is accepted
  // once it has been seen for DEBOUNCE_CYCLES consecutive cycles. The counter
  // saturates so a long-held key never wraps back into a re-acceptance window.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cand       <= 8'h00;
      cnt        <= '0;
      key_stable <= 8'h00;
    end else begin
      if (kc_q != cand) begin
        cand <= kc_q;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (cnt == CNT_MAX) begin
        key_stable <= cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Level commands and frame tick, all sampled on the frame edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_tick <= 1'b0;
      left       <= 2'b00;
      right      <= 2'b00;
    end else begin
      frame_tick <= fe;
      if (fe) begin
        left[0]  <= (key_stable == P0_LEFT);
        right[0] <= (key_stable == P0_RIGHT);
        left[1]  <= (key_stable == P1_LEFT);
        right[1] <= (key_stable == P1_RIGHT);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Jump FSMs. A press that lands on the same cycle as a frame edge only moves
  // IDLE -> PEND, so its pulse occupies the following full frame. Release in
  // PEND/FIRE does not cut the pulse short; HOLD then drops back to IDLE.
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] jump_step(input logic [1:0] st,
                                           input logic       pulse,
                                           input logic       hit,
                                           input logic       fe_i);
    logic [1:0] nxt;
    logic       pls;
    nxt = st;
    pls = pulse;
    case (st)
      ST_IDLE: if (hit) nxt = ST_PEND;
      ST_PEND: if (fe_i) begin
                 nxt = ST_FIRE;
                 pls = 1'b1;
               end
      ST_FIRE: if (fe_i) begin
                 nxt = ST_HOLD;
                 pls = 1'b0;
               end
      ST_HOLD: if (!hit) nxt = ST_IDLE;
      default: begin
                 nxt = ST_IDLE;
                 pls = 1'b0;
               end
    endcase
    return {nxt, pls};
  endfunction

  assign hit0 = (key_stable == P0_JUMP);
  assign hit1 = (key_stable == P1_JUMP);

  always_comb begin
    {st0_nxt, jump0_nxt} = jump_step(st0, jump[0], hit0, fe);
    {st1_nxt, jump1_nxt} = jump_step(st1, jump[1], hit1, fe);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st0  <= ST_IDLE;
      st1  <= ST_IDLE;
      jump <= 2'b00;
    end else begin
      st0  <= st0_nxt;
      st1  <= st1_nxt;
      jump <= {jump1_nxt, jump0_nxt};
    end
  end

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Directed bench for key_cmd_decoder with DEBOUNCE_CYCLES=4.
// vs has a 200-cycle period and is low for 10 cycles. The bench keeps its own
// frame phase counter ph: vs falls right after the edge where ph becomes 190,
// so the decoder registers the frame edge at the edge where ph becomes 192.
module tb_key_cmd_decoder;

  logic       Clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       vs;
  logic [7:0] key_stable;
  logic       frame_tick;
  logic [1:0] left;
  logic [1:0] right;
  logic [1:0] jump;

  int checks;
  int errors;
  int ph;

  key_cmd_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .vs         (vs),
    .key_stable (key_stable),
    .frame_tick (frame_tick),
    .left       (left),
    .right      (right),
    .jump       (jump)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Free-running vs generator with phase counter.
  initial begin
    vs = 1'b1;
    ph = 0;
    forever begin
      @(posedge Clk);
      #1;
      ph = (ph == 199) ? 0 : ph + 1;
      vs = (ph < 190);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 2 ns after the next edge at which ph becomes p.
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(posedge Clk);
      #2;
      n++;
    end while (ph != p && n < 401);
    if (ph != p) begin
      errors++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d", p, ph);
    end
  endtask

  task automatic test_reset();
    Reset   = 1'b0;
    keycode = 8'h00;
    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if ({key_stable, frame_tick, left, right, jump} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {key_stable, frame_tick, left, right, jump});
    end
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #2;
      checks++;
      if (frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_false_tick: frame_tick=%b expected 0", frame_tick);
      end
    end
  endtask

  task automatic test_glitch();
    wait_phase(10);
    keycode = 8'h04;
    repeat (3) @(posedge Clk);
    #2;
    keycode = 8'h00;
    repeat (10) @(posedge Clk);
    #2;
    checks++;
    if (key_stable !== 8'h00) begin
      errors++;
      $display("FAIL glitch_key_stable: got %h expected 00", key_stable);
    end
    wait_phase(192);
    checks++;
    if (left !== 2'b00) begin
      errors++;
      $display("FAIL glitch_left: got %b expected 00", left);
    end
  endtask

  task automatic test_hold_left();
    wait_phase(20);
    keycode = 8'h04;
    wait_phase(25);
    checks++;
    if (key_stable !== 8'h00) begin
      errors++;
      $display("FAIL debounce_early: got %h expected 00", key_stable);
    end
    wait_phase(26);
    checks++;
    if (key_stable !== 8'h04) begin
      errors++;
      $display("FAIL debounce_accept: got %h expected 04", key_stable);
    end
    wait_phase(191);
    checks++;
    if (left !== 2'b00 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL left_before_tick: left=%b tick=%b expected 00/0", left, frame_tick);
    end
    wait_phase(192);
    checks++;
    if (left !== 2'b01 || frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL left_at_tick: left=%b tick=%b expected 01/1", left, frame_tick);
    end
    wait_phase(193);
    checks++;
    if (frame_tick !== 1'b0 || left !== 2'b01) begin
      errors++;
      $display("FAIL tick_width: tick=%b left=%b expected 0/01", frame_tick, left);
    end
    wait_phase(20);
    keycode = 8'h00;
    wait_phase(191);
    checks++;
    if (left !== 2'b01) begin
      errors++;
      $display("FAIL left_held: got %b expected 01", left);
    end
    wait_phase(192);
    checks++;
    if (left !== 2'b00) begin
      errors++;
      $display("FAIL left_release: got %b expected 00", left);
    end
  endtask

  task automatic test_levels();
    logic [7:0] keys  [4] = '{8'h07, 8'h50, 8'h4F, 8'h1A};
    logic [1:0] exp_l [4] = '{2'b00, 2'b10, 2'b00, 2'b00};
    logic [1:0] exp_r [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
    for (int k = 0; k < 4; k++) begin
      wait_phase(20);
      keycode = keys[k];
      wait_phase(192);
      checks++;
      if (left !== exp_l[k] || right !== exp_r[k]) begin
        errors++;
        $display("FAIL levels_%h: left=%b right=%b expected %b/%b",
                 keys[k], left, right, exp_l[k], exp_r[k]);
      end
      wait_phase(20);
      keycode = 8'h00;
    end
    wait_phase(192);
    checks++;
    if (left !== 2'b00 || right !== 2'b00) begin
      errors++;
      $display("FAIL levels_idle: left=%b right=%b expected 00/00", left, right);
    end
  endtask

  // Press the key, expect one pulse while held for 3 frames, release, press
  // again and expect a second pulse.
  task automatic test_jump(input logic [7:0] key, input logic [1:0] exp);
    wait_phase(20);
    keycode = key;
    wait_phase(191);
    checks++;
    if (jump !== 2'b00) begin
      errors++;
      $display("FAIL jump_%h_pend: got %b expected 00", key, jump);
    end
    wait_phase(192);
    checks++;
    if (jump !== exp) begin
      errors++;
      $display("FAIL jump_%h_fire: got %b expected %b", key, jump, exp);
    end
    wait_phase(191);
    checks++;
    if (jump !== exp) begin
      errors++;
      $display("FAIL jump_%h_frame_end: got %b expected %b", key, jump, exp);
    end
    wait_phase(192);
    checks++;
    if (jump !== 2'b00) begin
      errors++;
      $display("FAIL jump_%h_end: got %b expected 00", key, jump);
    end
    wait_phase(192);
    checks++;
    if (jump !== 2'b00) begin
      errors++;
      $display("FAIL jump_%h_no_retrigger: got %b expected 00", key, jump);
    end
    wait_phase(20);
    keycode = 8'h00;
    wait_phase(50);
    keycode = key;
    wait_phase(192);
    checks++;
    if (jump !== exp) begin
      errors++;
      $display("FAIL jump_%h_second: got %b expected %b", key, jump, exp);
    end
    wait_phase(192);
    checks++;
    if (jump !== 2'b00) begin
      errors++;
      $display("FAIL jump_%h_second_end: got %b expected 00", key, jump);
    end
    wait_phase(20);
    keycode = 8'h00;
  endtask

  // key_stable becomes 52 at ph 191, so hit coincides with the frame edge.
  task automatic test_align();
    wait_phase(185);
    keycode = 8'h52;
    wait_phase(191);
    checks++;
    if (key_stable !== 8'h52) begin
      errors++;
      $display("FAIL align_key_stable: got %h expected 52", key_stable);
    end
    wait_phase(192);
    checks++;
    if (jump !== 2'b00) begin
      errors++;
      $display("FAIL align_not_current: got %b expected 00", jump);
    end
    wait_phase(192);
    checks++;
    if (jump !== 2'b10) begin
      errors++;
      $display("FAIL align_next_frame: got %b expected 10", jump);
    end
    wait_phase(192);
    checks++;
    if (jump !== 2'b00) begin
      errors++;
      $display("FAIL align_end: got %b expected 00", jump);
    end
    wait_phase(20);
    keycode = 8'h00;
  endtask

  task automatic test_reset_mid();
    wait_phase(20);
    keycode = 8'h1A;
    wait_phase(100);
    Reset = 1'b0;
    #1;
    checks++;
    if ({key_stable, frame_tick, left, right, jump} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0",
               {key_stable, frame_tick, left, right, jump});
    end
    keycode = 8'h00;
    wait_phase(110);
    Reset = 1'b1;
    wait_phase(192);
    checks++;
    if (jump !== 2'b00 || frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_no_pulse: jump=%b tick=%b expected 00/1", jump, frame_tick);
    end
    wait_phase(192);
    checks++;
    if (jump !== 2'b00 || key_stable !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_quiet: jump=%b key=%h expected 00/00", jump, key_stable);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset   = 1'b0;
    keycode = 8'h00;
    test_reset();
    test_glitch();
    test_hold_left();
    test_levels();
    test_jump(8'h1A, 2'b01);
    test_jump(8'h52, 2'b10);
    test_align();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
